// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port integer register file for the RV32 core.
//   - Two write ports: W0 (ALU / PC+4 writeback) and W1 (late load data).
//     When both hit the same register in one cycle, W1 wins.
//   - Two combinational read ports with same-cycle write-to-read bypass.
//   - One pending bit per register so decode can detect hazards.
//   - After reset, a clear sequence zeroes one entry per cycle while busy=1.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   busy                     high while the clear sequence runs
//   we0/waddr0/wdata0        write port W0
//   we1/waddr1/wdata1        write port W1
//   alloc_en/alloc_rd        mark a destination register as pending
//   raddr0/raddr1            read addresses
//   rdata0/rdata1            combinational read data
//   rready0/rready1          read data is valid (register not pending)
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_rd,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rready0,
    output logic              rready1
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam bit ZR = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W:0]   clr_idx;
    logic [DEPTH-1:0]  pending;
    logic [DATA_W-1:0] mem [DEPTH];

    logic run;
    logic wr0_ok;
    logic wr1_ok;
    logic alloc_ok;

    assign run  = (state == RUN);
    assign busy = ~run;

    // Effective write/alloc strobes: nothing lands while clearing, and
    // register 0 is hard-wired when ZERO_REG is set.
    assign wr0_ok   = run & we0 & ~(ZR & (waddr0 == '0));
    assign wr1_ok   = run & we1 & ~(ZR & (waddr1 == '0));
    assign alloc_ok = run & alloc_en & ~(ZR & (alloc_rd == '0));

    // Control state: clear sequencer and pending scoreboard. The alloc
    // update comes last so it overrides a write to the same register
    // (the newly issued instruction is the outstanding producer).
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            pending <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + IDX_ONE;
                    if (clr_idx == LAST_IDX) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (wr0_ok) begin
                        pending[waddr0] <= 1'b0;
                    end
                    if (wr1_ok) begin
                        pending[waddr1] <= 1'b0;
                    end
                    if (alloc_ok) begin
                        pending[alloc_rd] <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage array. W1 is written after W0 so it wins on a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_idx[ADDR_W-1:0]] <= '0;
            end else begin
                if (wr0_ok) begin
                    mem[waddr0] <= wdata0;
                end
                if (wr1_ok) begin
                    mem[waddr1] <= wdata1;
                end
            end
        end
    end

    // Read ports. Priority: busy, hard-wired zero, W1 bypass, W0 bypass,
    // then stored value qualified by the scoreboard.
    always_comb begin
        rdata0  = '0;
        rready0 = 1'b0;
        if (run) begin
            if (ZR && (raddr0 == '0)) begin
                rdata0  = '0;
                rready0 = 1'b1;
            end else if (we1 && (waddr1 == raddr0)) begin
                rdata0  = wdata1;
                rready0 = 1'b1;
            end else if (we0 && (waddr0 == raddr0)) begin
                rdata0  = wdata0;
                rready0 = 1'b1;
            end else begin
                rdata0  = mem[raddr0];
                rready0 = ~pending[raddr0];
            end
        end
    end

    always_comb begin
        rdata1  = '0;
        rready1 = 1'b0;
        if (run) begin
            if (ZR && (raddr1 == '0)) begin
                rdata1  = '0;
                rready1 = 1'b1;
            end else if (we1 && (waddr1 == raddr1)) begin
                rdata1  = wdata1;
                rready1 = 1'b1;
            end else if (we0 && (waddr0 == raddr1)) begin
                rdata1  = wdata0;
                rready1 = 1'b1;
            end else begin
                rdata1  = mem[raddr1];
                rready1 = ~pending[raddr1];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Self-checking bench for regfile_mp (DATA_W=32, DEPTH=32, ZERO_REG=1).
// A behavioural model tracks a busy countdown, register contents and
// pending flags; a compare process checks every DUT output each cycle,
// and directed vectors add hand-computed literal expectations.
module tb_regfile_mp;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic [4:0]  raddr0;
    logic [4:0]  raddr1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        rready0;
    logic        rready1;

    int checks = 0;
    int passes = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_pend [DEPTH];
    int          m_busy_left = 0;
    bit          m_valid = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .we0      (we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd),
        .raddr0   (raddr0),
        .raddr1   (raddr1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rready0  (rready0),
        .rready1  (rready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (checks=%0d passed=%0d)", checks, passes);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference read: what a read port must show given the model state
    // and the write inputs currently presented.
    function automatic void model_read(input logic [4:0] ra, output logic [31:0] d, output logic r);
        if (m_busy_left > 0) begin
            d = 32'h0;
            r = 1'b0;
        end else if (ra == 5'd0) begin
            d = 32'h0;
            r = 1'b1;
        end else if (we1 && waddr1 == ra) begin
            d = wdata1;
            r = 1'b1;
        end else if (we0 && waddr0 == ra) begin
            d = wdata0;
            r = 1'b1;
        end else begin
            d = m_mem[ra];
            r = !m_pend[ra];
        end
    endfunction

    // Model state update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b1;
            m_busy_left <= DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                m_pend[i] <= 1'b0;
            end
        end else if (m_valid) begin
            if (m_busy_left > 0) begin
                m_busy_left <= m_busy_left - 1;
                if (m_busy_left == 1) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        m_mem[i] <= 32'h0;
                    end
                end
            end else begin
                if (we0 && waddr0 != 5'd0) m_mem[waddr0] <= wdata0;
                if (we1 && waddr1 != 5'd0) m_mem[waddr1] <= wdata1;
                if (we0) m_pend[waddr0] <= 1'b0;
                if (we1) m_pend[waddr1] <= 1'b0;
                if (alloc_en && alloc_rd != 5'd0) m_pend[alloc_rd] <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        er0;
        logic        er1;
        if (m_valid) begin
            model_read(raddr0, ed0, er0);
            model_read(raddr1, ed1, er1);
            check_output("model_busy", 32'(busy), 32'(m_busy_left > 0));
            check_output("model_rdata0", rdata0, ed0);
            check_output("model_rdata1", rdata1, ed1);
            check_output("model_rready0", 32'(rready0), 32'(er0));
            check_output("model_rready1", 32'(rready1), 32'(er1));
        end
    end

    // Drive one cycle of inputs just after a rising edge, then return
    // just after the following falling edge so callers can sample.
    task automatic apply_stimulus(input logic r,
                                  input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                  input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                  input logic al, input logic [4:0] ar,
                                  input logic [4:0] r0, input logic [4:0] r1);
        @(posedge clk);
        #1;
        rst      = r;
        we0      = w0;
        waddr0   = a0;
        wdata0   = d0;
        we1      = w1;
        waddr1   = a1;
        wdata1   = d1;
        alloc_en = al;
        alloc_rd = ar;
        raddr0   = r0;
        raddr1   = r1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_read(input logic [4:0] r0, input logic [4:0] r1);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
    endtask

    initial begin
        int n;
        rst = 1'b1; we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        alloc_en = 1'b0; alloc_rd = '0; raddr0 = '0; raddr1 = '0;

        // Reset, then count busy cycles; try to write/alloc x9 while busy.
        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        check_output("reset_busy", 32'(busy), 32'd1);
        check_output("reset_rdata0", rdata0, 32'h0);
        check_output("reset_rready0", 32'(rready0), 32'd0);
        n = 0;
        do begin
            apply_stimulus(1'b0, (n < 3), 5'd9, 32'h0000_1234, 1'b0, 5'd0, 32'h0,
                           (n < 3), 5'd9, 5'd9, 5'd1);
            if (busy) n++;
        end while (busy && n < 100);
        check_output("clear_latency", 32'(n), 32'd32);

        // Every register reads 0 and ready after the clear.
        for (int i = 0; i < DEPTH; i++) begin
            idle_read(5'(i), 5'(DEPTH - 1 - i));
            check_output("post_clear_rdata0", rdata0, 32'h0);
            check_output("post_clear_rready0", 32'(rready0), 32'd1);
        end

        // Write then read, via bypass and from storage.
        apply_stimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
        check_output("bypass_w0", rdata0, 32'hDEAD_BEEF);
        check_output("bypass_w0_ready", 32'(rready0), 32'd1);
        idle_read(5'd5, 5'd9);
        check_output("stored_x5", rdata0, 32'hDEAD_BEEF);
        check_output("busy_write_dropped_x9", rdata1, 32'h0);
        check_output("busy_alloc_dropped_x9", 32'(rready1), 32'd1);

        // Port collision: W1 wins on bypass and storage.
        apply_stimulus(1'b0, 1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222, 1'b0, 5'd0, 5'd7, 5'd7);
        check_output("conflict_bypass0", rdata0, 32'h2222_2222);
        check_output("conflict_bypass1", rdata1, 32'h2222_2222);
        idle_read(5'd7, 5'd5);
        check_output("conflict_stored", rdata0, 32'h2222_2222);

        // Distinct registers on both ports in the same cycle.
        apply_stimulus(1'b0, 1'b1, 5'd10, 32'hA5A5_0010, 1'b1, 5'd11, 32'h5A5A_0011, 1'b0, 5'd0, 5'd11, 5'd10);
        check_output("dual_bypass0", rdata0, 32'h5A5A_0011);
        check_output("dual_bypass1", rdata1, 32'hA5A5_0010);
        idle_read(5'd10, 5'd11);
        check_output("dual_stored0", rdata0, 32'hA5A5_0010);
        check_output("dual_stored1", rdata1, 32'h5A5A_0011);

        // Zero register ignores writes and allocs.
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        check_output("zero_same_cycle", rdata0, 32'h0);
        check_output("zero_same_ready", 32'(rready0), 32'd1);
        idle_read(5'd0, 5'd0);
        check_output("zero_next_cycle", rdata0, 32'h0);
        check_output("zero_next_ready", 32'(rready0), 32'd1);

        // Scoreboard.
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
        idle_read(5'd3, 5'd5);
        check_output("alloc_pending", 32'(rready0), 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_0055, 1'b0, 5'd0, 5'd3, 5'd3);
        check_output("w1_bypass_ready", 32'(rready0), 32'd1);
        check_output("w1_bypass_data", rdata0, 32'h0000_0055);
        idle_read(5'd3, 5'd3);
        check_output("w1_cleared_ready", 32'(rready1), 32'd1);
        check_output("w1_stored", rdata1, 32'h0000_0055);
        apply_stimulus(1'b0, 1'b1, 5'd3, 32'h0000_0077, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd5, 5'd3);
        check_output("alloc_write_same_bypass", rdata1, 32'h0000_0077);
        idle_read(5'd5, 5'd3);
        check_output("alloc_wins_ready", 32'(rready1), 32'd0);
        check_output("alloc_wins_data", rdata1, 32'h0000_0077);

        // Reset in the middle of a clear sequence restarts it.
        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd5);
        for (int i = 0; i < 10; i++) begin
            idle_read(5'd3, 5'd5);
        end
        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd5);
        check_output("midclear_busy", 32'(busy), 32'd1);
        n = 0;
        do begin
            idle_read(5'd3, 5'd5);
            if (busy) n++;
        end while (busy && n < 100);
        check_output("restart_latency", 32'(n), 32'd32);
        check_output("restart_pending_cleared", 32'(rready0), 32'd1);
        check_output("restart_x3_zero", rdata0, 32'h0);
        check_output("restart_x5_zero", rdata1, 32'h0);

        idle_read(5'd0, 5'd0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32 core. It replaces the single-write-port file with two write ports: W0 for ALU/PC+4 writeback and W1 for late load data. It adds same-cycle write-to-read bypass, a per-register pending scoreboard for hazard detection, and a post-reset hardware clear sequence. It sits between decode (reads, allocation) and writeback (writes); the writeback data select stays outside the block.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, at least 2
- ADDR_W, $clog2(DEPTH), address width (derived)
- ZERO_REG, 1, when 1 entry 0 reads as 0, ignores writes and is never pending

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- busy  out  1  high while the clear sequence runs
- we0  in  1  write enable, port W0 (ALU/PC+4 writeback)
- waddr0  in  ADDR_W  write address, W0
- wdata0  in  DATA_W  write data, W0
- we1  in  1  write enable, port W1 (load writeback)
- waddr1  in  ADDR_W  write address, W1
- wdata1  in  DATA_W  write data, W1
- alloc_en  in  1  marks alloc_rd pending (instruction issued with a destination)
- alloc_rd  in  ADDR_W  register to mark pending
- raddr0, raddr1  in  ADDR_W  read addresses
- rdata0, rdata1  out  DATA_W  combinational read data
- rready0, rready1  out  1  read data is architecturally valid (not pending)

## Operation
- State machine has two states.
  - CLEAR: one entry is written with 0 per cycle, using clr_idx.
  - RUN: normal operation.
- rst=1 at an edge: state<=CLEAR, clr_idx<=0, all pending bits<=0.
- In CLEAR: mem[clr_idx]<=0 and clr_idx<=clr_idx+1. When clr_idx==DEPTH-1, that entry is cleared and state<=RUN.
- While busy: we0, we1 and alloc_en are ignored; rdata0/1=0; rready0/1=0.
- Writes in RUN:
  - mem[waddrN]<=wdataN for each enabled port.
  - If both ports target the same address, W1 wins.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Bypass: if raddrX matches an enabled write address this cycle, rdataX is that write data (W1 has priority over W0). Otherwise rdataX is mem[raddrX].
- With ZERO_REG=1, raddrX==0 gives rdataX=0 and rreadyX=1, overriding bypass.
- Scoreboard, one pending bit per register:
  - A write from either port clears pending[waddr].
  - alloc_en sets pending[alloc_rd].
  - If an alloc and a write hit the same address in the same cycle, the alloc wins and the bit ends set (new producer).
  - alloc_rd==0 with ZERO_REG=1 is ignored.
- rreadyX = !pending[raddrX], or 1 if raddrX is being written this cycle (bypassed).
- Data and pending values are unsigned bit vectors. No arithmetic except clr_idx, which is ADDR_W+1 bits wide and never wraps in CLEAR.

## Timing
- Reset values after the rst edge:
  - busy=1
  - rdata0/1=0
  - rready0/1=0
  - all pending bits 0
- Memory contents are undefined until CLEAR completes.
- Clear latency: busy stays high for exactly DEPTH cycles after the first edge with rst=0. The last cleared entry and state<=RUN happen on the same edge, so busy=0 in cycle DEPTH+1.
- rst held high keeps clr_idx=0 and busy=1. rst asserted mid-clear restarts the sequence from index 0.
- Read: zero-cycle latency (combinational from raddr, write inputs and stored state).
- Write and alloc: take effect at the next edge. The same-cycle view is given only by the bypass path.
- Scoreboard: a read in the cycle after an alloc sees rready=0.
- A write and a read of the same register in the same cycle give rready=1 and the new data.

## Test plan
- Reset, DEPTH=32: pulse rst for 1 cycle -> busy=1 for 32 cycles then 0. Every raddr then reads 0 with rready=1. A we0 issued while busy does not change any register.
- Write/read: we0 x5=0xDEADBEEF -> same cycle rdata0(raddr0=5)=0xDEADBEEF via bypass; next cycle the stored value is also 0xDEADBEEF.
- Port conflict: we0 x7=0x11111111 and we1 x7=0x22222222 in the same cycle -> rdata=0x22222222 both bypassed and stored.
- Zero register: we1 x0=0xFFFFFFFF and alloc x0 -> raddr0=0 gives rdata0=0, rready0=1 in all following cycles.
- Scoreboard:
  - alloc x3 -> next cycle rready(x3)=0.
  - we1 x3=0x55 -> same cycle rready=1, rdata=0x55.
  - alloc x3 and we0 x3 in the same cycle -> next cycle rready(x3)=0.
- Reset mid-clear: assert rst at clear cycle 10 -> busy stays high for a further full 32 cycles after rst falls. All pending bits are cleared.
